imul_share_arbiter: RTL

- Shares one iterative integer multiplier (same val/rdy stream interface as the pipeline's X-stage imul unit) among p_nreqs requesters, e.g. the cores of a multicore build.
- Sequences one transaction at a time: round-robin grant, issue, wait for the result, return the result to the owner.
- Sits between the per-core datapath imul ports and a single shared multiplier instance.

---
 rtl/imul_share_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/imul_share_arbiter.sv
// imul_share_arbiter: round-robin sharing of one iterative multiplier among p_nreqs requesters
//   clk, reset (sync, active-low)
//   req_val/req_rdy/req_msg    : per-requester {op_a, op_b} request streams
//   resp_val/resp_rdy/resp_msg : per-requester response handshakes, shared 32-bit result
//   mul_req_*/mul_resp_*       : stream interface to the single shared multiplier
//   busy                       : any state other than IDLE
//   owner                      : index of the current grant holder
module imul_share_arbiter #(
    parameter int p_nreqs = 4,
    localparam int c_owner_nbits = (p_nreqs > 1) ? $clog2(p_nreqs) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [p_nreqs-1:0]       req_val,
    output logic [p_nreqs-1:0]       req_rdy,
    input  logic [64*p_nreqs-1:0]    req_msg,
    output logic [p_nreqs-1:0]       resp_val,
    input  logic [p_nreqs-1:0]       resp_rdy,
    output logic [31:0]              resp_msg,
    output logic                     mul_req_val,
    input  logic                     mul_req_rdy,
    output logic [63:0]              mul_req_msg,
    input  logic                     mul_resp_val,
    output logic                     mul_resp_rdy,
    input  logic [31:0]              mul_resp_msg,
    output logic                     busy,
    output logic [c_owner_nbits-1:0] owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                   state, state_next;
    logic [c_owner_nbits-1:0] rr_ptr, grant;
    logic                     grant_val;
    logic [63:0]              msg;
    logic [31:0]              result;
    int                       idx;

    // Scan downward from rr_ptr+p_nreqs-1 so the last hit, i.e. the one
    // closest to rr_ptr, wins; indices wrap without needing a power of two.
    always_comb begin
        grant_val = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int i = p_nreqs - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= p_nreqs) idx = idx - p_nreqs;
            if (req_val[idx]) begin
                grant_val = 1'b1;
                grant     = c_owner_nbits'(idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = grant_val ? ISSUE : IDLE;
            ISSUE: state_next = mul_req_rdy ? WAIT : ISSUE;
            WAIT:  state_next = mul_resp_val ? RESP : WAIT;
            RESP:  state_next = resp_rdy[owner] ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            msg    <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_val) begin
                msg   <= req_msg[64*int'(grant) +: 64];
                owner <= grant;
            end
            if (state == WAIT && mul_resp_val) result <= mul_resp_msg;
            if (state == RESP && resp_rdy[owner])
                rr_ptr <= (owner == c_owner_nbits'(p_nreqs - 1)) ? '0 : owner + c_owner_nbits'(1);
        end
    end

    assign req_rdy      = (state == IDLE && grant_val) ? p_nreqs'(1) << grant : '0;
    assign resp_val     = (state == RESP) ? p_nreqs'(1) << owner : '0;
    assign resp_msg     = result;
    assign mul_req_val  = state == ISSUE;
    assign mul_req_msg  = msg;
    assign mul_resp_rdy = state == WAIT;
    assign busy         = state != IDLE;
endmodule
